iter_shift_ctrl: RTL and testbench

Multi-cycle sequencer for a 16-bit shift/rotate unit. It performs an arbitrary shift of 0–15 positions by applying repeated 2-position steps, followed by one final 1-position step when the amount is odd. The block sits beside the ALU and serves shift/rotate instructions that use a register-sourced amount. The pipeline stalls on busy and consumes the result on done.

---
 rtl/iter_shift_ctrl.sv | 100 ++++++++++
 tb/tb_iter_shift_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift/rotate sequencer: walks a 16-bit operand through 2-position steps,
// with one trailing 1-position step for odd amounts, and reports the result on done.
module iter_shift_ctrl #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  dataIn,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [1:0]         state;
  logic [1:0]         opReg;
  logic [DATA_W-1:0]  work;
  logic [SHAMT_W-1:0] remaining;

  logic               twoStep;
  logic [DATA_W-1:0]  stepOne;
  logic [DATA_W-1:0]  stepTwo;
  logic [DATA_W-1:0]  stepped;
  logic [SHAMT_W-1:0] remainingNext;

  // One step of the latched operation; the step size depends on how much is left.
  always_comb begin
    twoStep = (remaining >= SHAMT_W'(2));
    case (opReg)
      OP_ROL: begin
        stepOne = {work[DATA_W-2:0], work[DATA_W-1]};
        stepTwo = {work[DATA_W-3:0], work[DATA_W-1:DATA_W-2]};
      end
      OP_SLL: begin
        stepOne = {work[DATA_W-2:0], 1'b0};
        stepTwo = {work[DATA_W-3:0], 2'b00};
      end
      OP_SRA: begin
        stepOne = {work[DATA_W-1], work[DATA_W-1:1]};
        stepTwo = {{2{work[DATA_W-1]}}, work[DATA_W-1:2]};
      end
      default: begin
        stepOne = {1'b0, work[DATA_W-1:1]};
        stepTwo = {2'b00, work[DATA_W-1:2]};
      end
    endcase
    stepped       = twoStep ? stepTwo : stepOne;
    remainingNext = twoStep ? (remaining - SHAMT_W'(2)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opReg     <= 2'b00;
      work      <= '0;
      remaining <= '0;
      out       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opReg     <= op;
            work      <= dataIn;
            remaining <= shamt;
            if (shamt == '0) begin
              out   <= dataIn;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= stepped;
          remaining <= remainingNext;
          if (remainingNext == '0) begin
            out   <= stepped;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Scoreboard bench for iter_shift_ctrl: expected results and done timing come from a
// plain-arithmetic shift model; a monitor pops and compares on every done pulse.
module tb_iter_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] dataIn;
  logic [3:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] out;

  typedef struct {
    logic [15:0] result;
    int          doneCycle;
    int          occupancy;
  } expect_t;

  expect_t expQ[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busyRun  = 0;

  iter_shift_ctrl #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dataIn(dataIn),
    .shamt(shamt), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] d, input int n);
    case (o)
      2'b00:   return (d << n) | (d >> (16 - n));
      2'b01:   return d << n;
      2'b10:   return 16'($signed(d) >>> n);
      default: return d >> n;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Waits for IDLE, then presents one request and records what it must produce.
  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] d, input logic [3:0] n);
    expect_t e;
    int guard = 0;
    while (busy !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) checkOutput("idleTimeout", 32'(busy), 32'd0);
    start  = 1'b1;
    op     = o;
    dataIn = d;
    shamt  = n;
    e.result    = model(o, d, int'(n));
    e.doneCycle = cyc + 1 + (int'(n) + 1) / 2;
    e.occupancy = (int'(n) + 1) / 2 + 1;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((expQ.size() != 0 || busy !== 1'b0) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    expect_t e;
    if (busy === 1'b1) busyRun++;
    else busyRun = 0;
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", 32'(out), 32'(e.result));
        checkOutput("doneLatency", 32'(cyc), 32'(e.doneCycle));
        checkOutput("busyCycles", 32'(busyRun), 32'(e.occupancy));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; dataIn = '0; shamt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("resetOut", 32'(out), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
    end

    applyStimulus(2'b00, 16'h8001, 4'd3);
    applyStimulus(2'b10, 16'h8000, 4'd15);
    applyStimulus(2'b11, 16'h8000, 4'd15);
    applyStimulus(2'b01, 16'h1234, 4'd4);
    applyStimulus(2'b01, 16'hABCD, 4'd0);
    drain();

    // Requests arriving while busy (including the DONE cycle) must be dropped.
    applyStimulus(2'b11, 16'hF000, 4'd8);
    while (busy === 1'b1) begin
      start  = 1'b1;
      op     = 2'($urandom_range(0, 3));
      dataIn = 16'($urandom);
      shamt  = 4'($urandom_range(1, 15));
      @(negedge clk);
    end
    applyStimulus(2'b01, 16'h00FF, 4'd1);
    drain();

    // Reset in the second SHIFT cycle abandons the operation.
    applyStimulus(2'b00, 16'h1357, 4'd9);
    @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetOut", 32'(out), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetDone", 32'(done), 32'd0);
    applyStimulus(2'b00, 16'h0001, 4'd1);
    drain();

    for (int i = 0; i < 60; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
